mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between the instruction-fetch port and the data (load/store) port.
- Sits between the datapath/pipeline and the unified memory macro.
- Grants at most one access per cycle, with data priority by default and a starvation guard for fetch.
- Tracks in-flight reads in a latency pipeline and steers each response back to the port that issued it.

Parameters:
- XLEN, 32: data/address width.
- READ_LATENCY, 2: cycles from memory accept to mem_rdata valid; legal range 1..8.
- STARVE_LIMIT, 4: consecutive denied fetch cycles before fetch is forced to win; 0 disables the guard.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  XLEN  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  XLEN  fetch response data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_wmask  in  XLEN  store bit mask.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load response valid.
- d_rdata  out  XLEN  load response data.
- mem_req  out  1  memory access issued this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  write data.
- mem_wmask  out  XLEN  write mask.
- mem_ready  in  1  memory can accept an access this cycle.
- mem_rdata  in  XLEN  read data, READ_LATENCY cycles after accept.

Behaviour:
- Grant decision and payload mux are combinational in the same cycle.
  - Grant happens only when mem_ready=1.
  - mem_req = i_gnt | d_gnt; i_gnt and d_gnt are never both 1.
- Requesters hold req and payload stable until their gnt. The arbiter never drops or reorders a held request.
- Winner selection, fixed priority:
  - Data wins when d_req=1, unless starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0; then fetch wins.
  - Otherwise fetch wins if i_req=1.
- starve_cnt register, width clog2(STARVE_LIMIT+1), saturating:
  - Increments when i_req & mem_ready & d_gnt.
  - Clears on i_gnt or when i_req=0.
  - Holds when mem_ready=0.
- Muxed outputs for a fetch grant: mem_we=0, mem_addr=i_addr, mem_wdata=0, mem_wmask=0.
- Muxed outputs for a data grant: mem_we=d_we, plus d_addr/d_wdata/d_wmask.
- Muxed outputs with no grant: all mem_* = 0.
- Response pipeline: shift register of READ_LATENCY entries {valid, id}.
  - Stage 0 loads {1,0} on a fetch grant, {1,1} on a data load grant, and {0,x} on a store or no grant.
  - The last stage drives i_rvalid (id=0) or d_rvalid (id=1).
  - Both rdata outputs carry mem_rdata; consumers qualify with rvalid.
  - Stores produce no response.
- Throughput: one access per cycle, back-to-back. Responses return in grant order, exactly READ_LATENCY cycles after the grant.
- Reset asserted, including mid-operation:
  - Pipeline valids, starve_cnt and the RR pointer clear immediately.
  - In-flight reads are dropped; no rvalid appears for pre-reset grants.
  - While reset is asserted, all gnt/rvalid/mem_req are 0.
- Simultaneous grant and response in the same cycle are independent and both occur.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration replaces fixed priority and the starvation guard; starve_cnt is not built.
  - A 1-bit last-winner pointer updates on every grant.
  - On contention, the port that did not win last is granted. With one requester, that requester wins.
  - The pointer resets to "fetch won last", so data wins the first contention.
- Undefined: fixed priority with STARVE_LIMIT guard as above.

Test Plan:
- Fetch only, i_req=1 at addr 0x100, mem_ready=1, READ_LATENCY=2 -> i_gnt same cycle; mem_addr=0x100, mem_we=0; i_rvalid=1 exactly 2 cycles later with mem_rdata; d_rvalid stays 0.
- i_req and d_req held for 10 cycles, d_we=0, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I,D,D,D,D,I; responses return with matching ids in grant order.
- Store d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=0xFF -> mem_we=1 with that payload; no d_rvalid ever follows.
- mem_ready=0 for 3 cycles with both requests pending -> no gnt, mem_req=0, starve_cnt unchanged; on mem_ready=1, data is granted first.
- Two loads granted, reset pulled low one cycle after the second grant, released next cycle -> no i_rvalid/d_rvalid for either load; the first post-reset grant behaves normally.
- With MEM_ARB_RR_EN defined and both requests held -> grants alternate D,I,D,I starting with D.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, fixed-latency memory between an instruction-fetch
// port (i_*) and a data load/store port (d_*). At most one access is granted
// per cycle. The grant decision and the payload mux are combinational. Every
// read that is granted is tracked in a READ_LATENCY-deep pipeline, so that its
// response can be steered back to the port that issued it.
//
// Handshake: a requester raises *_req with a stable payload. It holds both
// until the cycle in which *_gnt is 1. That cycle is the transfer, and the
// arbiter only grants while mem_ready=1. The responses (*_rvalid) are
// single-cycle pulses and carry no back-pressure. Both *_rdata outputs carry
// mem_rdata, so a consumer must qualify the data with its own *_rvalid.
//
// Arbitration:
//   default          : data has fixed priority. A starvation guard forces
//                      fetch to win once it has been passed over STARVE_LIMIT
//                      times in a row. STARVE_LIMIT=0 disables the guard.
//   MEM_ARB_RR_EN    : (macro defined) round-robin on contention, tracked by
//                      a 1-bit last-winner pointer. This mode builds no
//                      starvation counter.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   i_req/i_addr          fetch request and address
//   i_gnt                 fetch accepted this cycle
//   i_rvalid/i_rdata      fetch response
//   d_req/d_we/d_addr     data request, store flag, address
//   d_wdata/d_wmask       store data and bit mask
//   d_gnt                 data accepted this cycle
//   d_rvalid/d_rdata      load response
//   mem_req/mem_we        memory access issued, write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_wmask             memory write bit mask
//   mem_ready             memory can accept an access this cycle
//   mem_rdata             read data, READ_LATENCY cycles after accept
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int READ_LATENCY = 2,   // legal range 1..8
  parameter int STARVE_LIMIT = 4    // 0 disables the fetch starvation guard
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [XLEN-1:0] d_wmask,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,

  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_wmask,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  logic w_fetch_wins;
  logic w_data_wins;
  logic w_rd_issue;

`ifdef MEM_ARB_RR_EN
  // 1 = data won the most recent grant. The reset value is "fetch won last",
  // so data takes the first contention.
  logic r_last_data;

  always_comb begin
    w_fetch_wins = 1'b0;
    w_data_wins  = 1'b0;
    // A grant needs reset to be released. This keeps all gnt/mem_req low
    // while reset is held.
    if (reset && mem_ready) begin
      if (i_req && d_req) begin
        w_fetch_wins = r_last_data;
        w_data_wins  = ~r_last_data;
      end else begin
        w_fetch_wins = i_req;
        w_data_wins  = d_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_data <= 1'b0;
    end else if (w_fetch_wins || w_data_wins) begin
      r_last_data <= w_data_wins;
    end
  end
`else
  // The counter must still be at least 1 bit wide when the guard is disabled.
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [SW-1:0] r_starve_cnt;
  logic          w_starved;

  assign w_starved = (STARVE_LIMIT != 0) && (r_starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    w_fetch_wins = 1'b0;
    w_data_wins  = 1'b0;
    if (reset && mem_ready) begin
      if (d_req && !(w_starved && i_req)) begin
        w_data_wins = 1'b1;
      end else if (i_req) begin
        w_fetch_wins = 1'b1;
      end
    end
  end

  // Counts how many consecutive grants have gone to data while fetch was
  // waiting. Cycles where the memory stalls leave the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (!i_req || w_fetch_wins) begin
      r_starve_cnt <= '0;
    end else if (w_data_wins && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end
`endif

  assign i_gnt   = w_fetch_wins;
  assign d_gnt   = w_data_wins;
  assign mem_req = w_fetch_wins | w_data_wins;

  // Payload mux. A fetch never writes, so its wdata and wmask are forced to 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (w_data_wins) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wmask = d_wmask;
    end else if (w_fetch_wins) begin
      mem_addr  = i_addr;
    end
  end

  // Response pipeline. Stage k holds {valid, id} of the read granted k+1
  // cycles ago, with id 0 = fetch and id 1 = data. Stores enter as invalid,
  // so they never produce a response.
  assign w_rd_issue = w_fetch_wins | (w_data_wins & ~d_we);

  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [READ_LATENCY-1:0] r_pipe_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_issue;
      r_pipe_id[0]  <= w_data_wins;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_id[k]  <= r_pipe_id[k-1];
      end
    end
  end

  assign i_rvalid = r_pipe_vld[READ_LATENCY-1] & ~r_pipe_id[READ_LATENCY-1];
  assign d_rvalid = r_pipe_vld[READ_LATENCY-1] &  r_pipe_id[READ_LATENCY-1];
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (XLEN=32, READ_LATENCY=2, STARVE_LIMIT=4).
// The driver tasks issue directed and random requests. At every falling edge,
// the monitor predicts the grant and the payload from a reference model of the
// arbitration rules. For each predicted read it queues the expected response,
// with its data taken from a reference memory and a due cycle. It then pops
// and compares that response when it falls due. A separate environment memory
// reacts to the DUT's actual mem_* outputs and feeds mem_rdata back.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int XLEN  = 32;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, i_gnt, i_rvalid;
  logic [XLEN-1:0] i_addr, i_rdata;
  logic            d_req, d_we, d_gnt, d_rvalid;
  logic [XLEN-1:0] d_addr, d_wdata, d_wmask, d_rdata;
  logic            mem_req, mem_we, mem_ready;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .READ_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic            id;    // 0 = fetch, 1 = data
    logic [XLEN-1:0] data;
    int              due;
  } rsp_t;
  rsp_t exp_q[$];

  // Reference model state: the rules of the arbiter stated abstractly.
  int              passed_over = 0;    // consecutive data grants while fetch waited
  bit              last_was_data = 0;  // round-robin history
  logic [XLEN-1:0] ref_mem[logic [XLEN-1:0]];

  // Environment memory, driven by what the DUT actually issues.
  logic [XLEN-1:0] env_mem[logic [XLEN-1:0]];
  logic [XLEN-1:0] slot_data[16];
  bit              slot_vld[16];

  bit  i_gnt_seen = 0;
  bit  d_gnt_seen = 0;
  bit  log_en = 0;
  byte gnt_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] init_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [XLEN-1:0] ref_read(input logic [XLEN-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [XLEN-1:0] env_read(input logic [XLEN-1:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_word(a);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bit              exp_i, exp_d, h_i, h_d;
    logic [XLEN-1:0] e_addr, e_wdata, e_wmask, h_data;
    rsp_t            h, r;
    if (!reset) begin
      check("rst_i_gnt",    i_gnt,    1'b0);
      check("rst_d_gnt",    d_gnt,    1'b0);
      check("rst_mem_req",  mem_req,  1'b0);
      check("rst_i_rvalid", i_rvalid, 1'b0);
      check("rst_d_rvalid", d_rvalid, 1'b0);
      exp_q.delete();
      passed_over   = 0;
      last_was_data = 0;
      i_gnt_seen    = 0;
      d_gnt_seen    = 0;
    end else begin
      // Expected response for this cycle.
      h_i = 0; h_d = 0; h_data = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        h = exp_q.pop_front();
        h_i = !h.id;
        h_d = h.id;
        h_data = h.data;
      end
      check("i_rvalid", i_rvalid, h_i);
      check("d_rvalid", d_rvalid, h_d);
      if (h_i) check("i_rdata", i_rdata, h_data);
      if (h_d) check("d_rdata", d_rdata, h_data);

      // Expected winner.
      exp_i = 0; exp_d = 0;
      if (mem_ready) begin
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
          exp_d = !last_was_data;
          exp_i = last_was_data;
        end else begin
          exp_d = d_req;
          exp_i = i_req;
        end
`else
        if (d_req && !(i_req && passed_over >= LIMIT)) exp_d = 1;
        else if (i_req) exp_i = 1;
`endif
      end
      e_addr  = exp_d ? d_addr  : (exp_i ? i_addr : '0);
      e_wdata = exp_d ? d_wdata : '0;
      e_wmask = exp_d ? d_wmask : '0;
      check("i_gnt",     i_gnt,     exp_i);
      check("d_gnt",     d_gnt,     exp_d);
      check("mem_req",   mem_req,   exp_i | exp_d);
      check("mem_we",    mem_we,    exp_d & d_we);
      check("mem_addr",  mem_addr,  e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("mem_wmask", mem_wmask, e_wmask);

      // Queue expected responses; apply expected stores to the reference memory.
      if (exp_i || (exp_d && !d_we)) begin
        r.id   = exp_d;
        r.data = ref_read(e_addr);
        r.due  = cyc + LAT;
        exp_q.push_back(r);
      end
      if (exp_d && d_we) ref_mem[d_addr] = (ref_read(d_addr) & ~d_wmask) | (d_wdata & d_wmask);

      // Advance the model history.
`ifdef MEM_ARB_RR_EN
      if (exp_i || exp_d) last_was_data = exp_d;
`else
      if (!i_req || exp_i) passed_over = 0;
      else if (exp_d && passed_over < LIMIT) passed_over++;
`endif

      // Environment memory answers what the DUT actually issued.
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          env_mem[mem_addr] = (env_read(mem_addr) & ~mem_wmask) | (mem_wdata & mem_wmask);
        end else begin
          slot_data[(cyc + LAT) % 16] = env_read(mem_addr);
          slot_vld[(cyc + LAT) % 16]  = 1;
        end
      end

      i_gnt_seen = i_gnt;
      d_gnt_seen = d_gnt;
      if (log_en) begin
        if (d_gnt) gnt_log.push_back("D");
        else if (i_gnt) gnt_log.push_back("I");
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to the next cycle. Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (slot_vld[cyc % 16]) mem_rdata = slot_data[cyc % 16];
    else mem_rdata = $urandom();
    slot_vld[cyc % 16] = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      i_req = 0; d_req = 0; mem_ready = 1;
    end
  endtask

  task automatic pulse_reset();
    tick();
    reset = 0; i_req = 0; d_req = 0;
    tick();
    reset = 1;
  endtask

  task automatic check_pattern(input string name, input string exp_pat);
    check({name, "_len"}, gnt_log.size(), exp_pat.len());
    for (int k = 0; k < exp_pat.len() && k < gnt_log.size(); k++)
      check(name, gnt_log[k], exp_pat[k]);
    gnt_log.delete();
  endtask

  // Both ports requesting loads. A port draws a new address after each grant.
  task automatic both_loads(input bit ready);
    tick();
    if (i_gnt_seen || !i_req) i_addr = 32'($urandom_range(0, 63)) << 2;
    if (d_gnt_seen || !d_req) d_addr = 32'($urandom_range(0, 63)) << 2;
    i_req = 1; d_req = 1; d_we = 0; mem_ready = ready;
  endtask

  task automatic rand_cycle(input int n);
    tick();
    reset = (n % 300 != 150);
    if (!i_req || i_gnt_seen) begin
      i_req  = ($urandom_range(0, 3) != 0);
      i_addr = 32'($urandom_range(0, 31)) << 2;
    end
    if (!d_req || d_gnt_seen) begin
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = ($urandom_range(0, 2) == 0);
      d_addr  = 32'($urandom_range(0, 31)) << 2;
      d_wdata = $urandom();
      d_wmask = $urandom();
    end
    mem_ready = ($urandom_range(0, 5) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; mem_ready = 1; mem_rdata = '0;
    tick(); tick();
    reset = 1;
    idle(2);

    // Fetch only: granted in the same cycle, response LAT cycles later.
    tick();
    i_req = 1; i_addr = 32'h100; d_req = 0; mem_ready = 1;
    idle(4);

    // Both held for ten cycles from a clean state.
    pulse_reset();
    log_en = 1;
    for (int k = 0; k < 10; k++) both_loads(1);
    idle(1);
    log_en = 0;
`ifdef MEM_ARB_RR_EN
    check_pattern("pattern10", "DIDIDIDIDI");
`else
    check_pattern("pattern10", "DDDDIDDDDI");
`endif
    idle(3);

    // Store with no response, then fetch the same word to see the masked merge.
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wmask = 32'hFF;
    i_req = 0; mem_ready = 1;
    tick();
    d_req = 0; d_we = 0;
    i_req = 1; i_addr = 32'h2000;
    idle(4);

    // Memory stall in the middle of contention.
    pulse_reset();
    log_en = 1;
    both_loads(1); both_loads(1);
    both_loads(0); both_loads(0); both_loads(0);
    both_loads(1); both_loads(1); both_loads(1);
    idle(1);
    log_en = 0;
`ifdef MEM_ARB_RR_EN
    check_pattern("stall", "DIDID");
`else
    check_pattern("stall", "DDDDI");
`endif
    idle(3);

    // Two loads in flight, reset one cycle after the second grant.
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h40; i_req = 0; mem_ready = 1;
    tick();
    d_req = 0; i_req = 1; i_addr = 32'h80;
    tick();
    i_req = 0; reset = 0;
    tick();
    reset = 1;
    tick();
    i_req = 1; i_addr = 32'h44;
    idle(4);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) rand_cycle(n);
    reset = 1;
    idle(LAT + 4);
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
